// File: rtl/lsq_mem_pkg.sv
// Shared LSQ <-> data-memory definitions: widths, LS/BMS encodings, response record.
// No latency of its own; the response record is what the memory pipeline carries.
// No flow control here; the memory side accepts one request per cycle without backpressure.
package lsq_mem_pkg;

    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    localparam logic LS_LOAD  = 1'b1;
    localparam logic LS_STORE = 1'b0;
    localparam logic BMS_BYTE = 1'b1;
    localparam logic BMS_WORD = 1'b0;

    typedef struct packed {
        logic              valid;
        logic              ls;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } mem_rsp_t;

    // LB semantics: byte sign-extended to a full word.
    function automatic logic [DATA_W-1:0] sext_byte(input logic [7:0] b);
        return {{(DATA_W-8){b[7]}}, b};
    endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// LSQ <-> data memory request/response bundle; master = LSQ, slave = memory responder.
// Combinational wiring only, no latency.
// No ready signal: every request presented with mem_valid is accepted.
interface data_memory_responder_if;
    import lsq_mem_pkg::*;

    logic              mem_valid;
    logic              mem_LS;
    logic              mem_BMS;
    logic [DATA_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_store_value;
    logic [TAG_W-1:0]  mem_tag;

    logic              mem_valid_out;
    logic              mem_LS_out;
    logic [DATA_W-1:0] mem_addr_out;
    logic [DATA_W-1:0] mem_load_value_out;
    logic [TAG_W-1:0]  mem_tag_out;
    logic              mem_err_out;

    modport master (
        output mem_valid, mem_LS, mem_BMS, mem_address, mem_store_value, mem_tag,
        input  mem_valid_out, mem_LS_out, mem_addr_out, mem_load_value_out,
               mem_tag_out, mem_err_out
    );

    modport slave (
        input  mem_valid, mem_LS, mem_BMS, mem_address, mem_store_value, mem_tag,
        output mem_valid_out, mem_LS_out, mem_addr_out, mem_load_value_out,
               mem_tag_out, mem_err_out
    );

endinterface

// File: rtl/mem_delay_pipe.sv
// LATENCY-stage shift register of memory response records.
// Latency: exactly LATENCY cycles from rsp_i to rsp_o.
// No backpressure: advances every cycle; reset clears every stage.
module mem_delay_pipe
    import lsq_mem_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  mem_rsp_t rsp_i,
    output mem_rsp_t rsp_o
);

    mem_rsp_t stage_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= rsp_i;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign rsp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: byte/word little-endian access, in-order tagged completions.
// Latency: LATENCY cycles from acceptance; optional misaligned-word trap via MEM_MISALIGN_TRAP_EN.
// No backpressure: one request per cycle always accepted, responses cannot stall.
module data_memory_responder
    import lsq_mem_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input  logic clk,
    input  logic rst_n,
    data_memory_responder_if.slave bus
);

    localparam int AW = $clog2(MEM_BYTES);

    logic [7:0]        mem_q [MEM_BYTES];
    logic [AW-1:0]     byte_addr;
    logic [AW-1:0]     eff_addr;
    logic              is_byte;
    logic              is_load;
    logic              misalign;
    logic              wr_en;
    logic [7:0]        lane [4];
    logic [DATA_W-1:0] rd_data;
    mem_rsp_t          rsp_d;
    mem_rsp_t          rsp_q;

    assign byte_addr = bus.mem_address[AW-1:0];
    assign is_byte   = (bus.mem_BMS == BMS_BYTE);
    assign is_load   = (bus.mem_LS == LS_LOAD);
    assign eff_addr  = is_byte ? byte_addr : {byte_addr[AW-1:2], 2'b00};

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = !is_byte && (bus.mem_address[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign lane[k] = mem_q[eff_addr + AW'(k)];
    end

    // Requests seen while in reset must not touch the array.
    assign wr_en = rst_n && bus.mem_valid && !is_load && !misalign;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (is_byte) begin
                mem_q[eff_addr] <= bus.mem_store_value[7:0];
            end else begin
                for (int k = 0; k < 4; k++) begin
                    mem_q[eff_addr + AW'(k)] <= bus.mem_store_value[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (is_load && !misalign) begin
            rd_data = is_byte ? sext_byte(lane[0]) : {lane[3], lane[2], lane[1], lane[0]};
        end
    end

    always_comb begin
        rsp_d = '0;
        if (bus.mem_valid) begin
            rsp_d.valid = 1'b1;
            rsp_d.ls    = bus.mem_LS;
            rsp_d.addr  = bus.mem_address;
            rsp_d.data  = rd_data;
            rsp_d.tag   = bus.mem_tag;
            rsp_d.err   = misalign;
        end
    end

    mem_delay_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .rsp_i (rsp_d),
        .rsp_o (rsp_q)
    );

    assign bus.mem_valid_out      = rsp_q.valid;
    assign bus.mem_LS_out         = rsp_q.ls;
    assign bus.mem_addr_out       = rsp_q.addr;
    assign bus.mem_load_value_out = rsp_q.data;
    assign bus.mem_tag_out        = rsp_q.tag;
    assign bus.mem_err_out        = rsp_q.err;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: hand-computed responses checked through chk().
module tb_data_memory_responder;
    import lsq_mem_pkg::*;

    localparam int MEMB = 1024;
    localparam int LAT  = 2;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;

    data_memory_responder_if bus();

    data_memory_responder #(
        .MEM_BYTES (MEMB),
        .LATENCY   (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        ls;
        logic [31:0] addr;
        logic [31:0] data;
        logic [5:0]  tag;
        logic        err;
        int          cyc;
    } obs_t;

    obs_t mon_q[$];
    int   issue_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.mem_valid_out) begin
            mon_q.push_back('{bus.mem_LS_out, bus.mem_addr_out, bus.mem_load_value_out,
                              bus.mem_tag_out, bus.mem_err_out, cyc});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic ls, input logic bms, input logic [31:0] addr,
                        input logic [31:0] val, input logic [5:0] tag);
        @(posedge clk);
        #1;
        bus.mem_valid       = 1'b1;
        bus.mem_LS          = ls;
        bus.mem_BMS         = bms;
        bus.mem_address     = addr;
        bus.mem_store_value = val;
        bus.mem_tag         = tag;
        issue_q.push_back(cyc);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.mem_valid = 1'b0;
    endtask

    task automatic get_rsp(input string name, input logic ls, input logic [31:0] addr,
                           input logic [31:0] data, input logic [5:0] tag, input logic err);
        obs_t o;
        int   w;
        int   ic;
        w = 0;
        while (mon_q.size() == 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (mon_q.size() == 0) begin
            chk({name, " timeout"}, 32'd0, 32'd1);
            return;
        end
        o  = mon_q.pop_front();
        ic = (issue_q.size() != 0) ? issue_q.pop_front() : -1;
        chk({name, " ls"},   {31'd0, o.ls},  {31'd0, ls});
        chk({name, " addr"}, o.addr,         addr);
        chk({name, " data"}, o.data,         data);
        chk({name, " tag"},  {26'd0, o.tag}, {26'd0, tag});
        chk({name, " err"},  {31'd0, o.err}, {31'd0, err});
        chk({name, " lat"},  32'(o.cyc - ic), 32'(LAT));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        rst_n = 1'b0;
        bus.mem_valid       = 1'b0;
        bus.mem_LS          = LS_STORE;
        bus.mem_BMS         = BMS_WORD;
        bus.mem_address     = '0;
        bus.mem_store_value = '0;
        bus.mem_tag         = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst valid", {31'd0, bus.mem_valid_out}, 32'd0);
        chk("rst data",  bus.mem_load_value_out, 32'd0);
        chk("rst addr",  bus.mem_addr_out, 32'd0);
        chk("rst tag",   {26'd0, bus.mem_tag_out}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Word store then word load
        send(LS_STORE, BMS_WORD, 32'h10, 32'hDEADBEEF, 6'd5);
        send(LS_LOAD,  BMS_WORD, 32'h10, 32'h0,        6'd6);
        idle();
        get_rsp("st1", LS_STORE, 32'h10, 32'h0,        6'd5, 1'b0);
        get_rsp("ld1", LS_LOAD,  32'h10, 32'hDEADBEEF, 6'd6, 1'b0);

        // Byte lanes and sign extension
        send(LS_STORE, BMS_WORD, 32'h10, 32'h11223344, 6'd7);
        send(LS_STORE, BMS_BYTE, 32'h13, 32'h12345680, 6'd8);
        send(LS_LOAD,  BMS_WORD, 32'h10, 32'h0,        6'd9);
        send(LS_LOAD,  BMS_BYTE, 32'h13, 32'h0,        6'd10);
        send(LS_LOAD,  BMS_BYTE, 32'h10, 32'h0,        6'd11);
        idle();
        get_rsp("st2",  LS_STORE, 32'h10, 32'h0,        6'd7,  1'b0);
        get_rsp("stb",  LS_STORE, 32'h13, 32'h0,        6'd8,  1'b0);
        get_rsp("ldw",  LS_LOAD,  32'h10, 32'h80223344, 6'd9,  1'b0);
        get_rsp("ldb3", LS_LOAD,  32'h13, 32'hFFFFFF80, 6'd10, 1'b0);
        get_rsp("ldb0", LS_LOAD,  32'h10, 32'h00000044, 6'd11, 1'b0);

        // Back-to-back tags 1..4 (latency check per response implies no gaps)
        for (int i = 1; i <= 4; i++) send(LS_LOAD, BMS_WORD, 32'h10, 32'h0, 6'(i));
        idle();
        for (int i = 1; i <= 4; i++) get_rsp("b2b", LS_LOAD, 32'h10, 32'h80223344, 6'(i), 1'b0);

        // Address wrap and top byte
        send(LS_STORE, BMS_WORD, MEMB + 4,    32'hA5A5A5A5, 6'd12);
        send(LS_LOAD,  BMS_WORD, 32'h4,       32'h0,        6'd13);
        send(LS_STORE, BMS_BYTE, MEMB - 1,    32'h0000007F, 6'd14);
        send(LS_LOAD,  BMS_BYTE, MEMB - 1,    32'h0,        6'd15);
        idle();
        get_rsp("wrap st", LS_STORE, MEMB + 4, 32'h0,        6'd12, 1'b0);
        get_rsp("wrap ld", LS_LOAD,  32'h4,    32'hA5A5A5A5, 6'd13, 1'b0);
        get_rsp("top st",  LS_STORE, MEMB - 1, 32'h0,        6'd14, 1'b0);
        get_rsp("top ld",  LS_LOAD,  MEMB - 1, 32'h0000007F, 6'd15, 1'b0);

        // Reset with two requests in flight; a request during reset is ignored
        send(LS_STORE, BMS_WORD, 32'h40, 32'hCAFEF00D, 6'd20);
        send(LS_LOAD,  BMS_WORD, 32'h40, 32'h0,        6'd21);
        @(posedge clk);
        #2 rst_n = 1'b0;
        bus.mem_LS          = LS_STORE;
        bus.mem_store_value = 32'hBAD0BAD0;
        @(negedge clk);
        chk("mid rst valid", {31'd0, bus.mem_valid_out}, 32'd0);
        chk("mid rst tag",   {26'd0, bus.mem_tag_out}, 32'd0);
        repeat (2) @(posedge clk);
        #1 bus.mem_valid = 1'b0;
        rst_n = 1'b1;
        issue_q.delete();
        repeat (LAT + 3) @(negedge clk);
        chk("dropped rsps", 32'(mon_q.size()), 32'd0);
        mon_q.delete();
        send(LS_LOAD, BMS_WORD, 32'h40, 32'h0, 6'd22);
        idle();
        get_rsp("post rst ld", LS_LOAD, 32'h40, 32'hCAFEF00D, 6'd22, 1'b0);

        // Misaligned word store
        send(LS_STORE, BMS_WORD, 32'h20, 32'h55667788, 6'd30);
        send(LS_STORE, BMS_WORD, 32'h21, 32'h99AABBCC, 6'd31);
        send(LS_LOAD,  BMS_WORD, 32'h20, 32'h0,        6'd32);
        idle();
        get_rsp("mis base", LS_STORE, 32'h20, 32'h0, 6'd30, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
        get_rsp("mis st", LS_STORE, 32'h21, 32'h0,        6'd31, 1'b1);
        get_rsp("mis ld", LS_LOAD,  32'h20, 32'h55667788, 6'd32, 1'b0);
`else
        get_rsp("mis st", LS_STORE, 32'h21, 32'h0,        6'd31, 1'b0);
        get_rsp("mis ld", LS_LOAD,  32'h20, 32'h99AABBCC, 6'd32, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("no extra rsps", 32'(mon_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
